// File: rtl/dsp_pkg.sv
// ============================================================================
// Module      : dsp_pkg
// Description : Shared width, frame length and FSM state type for dsp_accum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsp_pkg;

    localparam int DSP_P_W       = 48;
    localparam int DEF_FRAME_LEN = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        OUT_WAIT = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dsp_sat_add.sv
// ============================================================================
// Module      : dsp_sat_add
// Description : Combinational unsigned saturating adder with overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_sat_add #(
    parameter int W = 48
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};
    assign ovf    = w_full[W];
    assign sum    = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

`default_nettype wire

// File: rtl/dsp_accum.sv
// ============================================================================
// Module      : dsp_accum
// Description : Sums FRAME_LEN unsigned DSP results per frame with saturation
//               and a valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_accum
    import dsp_pkg::*;
#(
    parameter int FRAME_LEN = dsp_pkg::DEF_FRAME_LEN,
    parameter int P_W       = dsp_pkg::DSP_P_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic [P_W-1:0] p_in,
    input  logic           p_valid,
    output logic           p_ready,
    output logic [P_W-1:0] sum_out,
    output logic           sum_valid,
    input  logic           sum_ready,
    output logic           sum_ovf
);

    localparam logic [7:0] c_LAST = 8'(FRAME_LEN - 1);

    state_t         r_state;
    logic [P_W-1:0] r_acc;
    logic [7:0]     r_count;
    logic           r_sticky;

    logic [P_W-1:0] w_sum;
    logic           w_ovf;
    logic           w_accept;
    logic           w_hs;
    logic           w_last;

    // acc is held at zero between frames, so the first sample needs no mux.
    dsp_sat_add #(
        .W (P_W)
    ) u_sat_add (
        .a   (r_acc),
        .b   (p_in),
        .sum (w_sum),
        .ovf (w_ovf)
    );

    assign p_ready  = (r_state == OUT_WAIT) ? sum_ready : 1'b1;
    assign w_accept = p_valid & p_ready;
    assign w_hs     = sum_valid & sum_ready;
    assign w_last   = w_accept & (r_count == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_count   <= '0;
            r_sticky  <= 1'b0;
            sum_out   <= '0;
            sum_ovf   <= 1'b0;
            sum_valid <= 1'b0;
        end else if (clr) begin
            r_acc    <= '0;
            r_count  <= '0;
            r_sticky <= 1'b0;
            if (w_hs) begin
                sum_valid <= 1'b0;
                r_state   <= IDLE;
            end else if (r_state != OUT_WAIT) begin
                r_state <= IDLE;
            end
        end else if (w_last) begin
            sum_out   <= w_sum;
            sum_ovf   <= r_sticky | w_ovf;
            sum_valid <= 1'b1;
            r_acc     <= '0;
            r_count   <= '0;
            r_sticky  <= 1'b0;
            r_state   <= OUT_WAIT;
        end else begin
            if (w_accept) begin
                r_acc    <= w_sum;
                r_count  <= r_count + 8'd1;
                r_sticky <= r_sticky | w_ovf;
            end
            // In OUT_WAIT an accepted sample always coincides with the handshake.
            if (w_hs) begin
                sum_valid <= 1'b0;
                r_state   <= (w_accept || (r_count != 8'd0)) ? ACCUM : IDLE;
            end else if (w_accept) begin
                r_state <= ACCUM;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dsp_accum.sv
// ============================================================================
// Module      : tb_dsp_accum
// Description : Directed and randomized self-checking bench for dsp_accum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp_accum;

    localparam int P_W = 48;
    localparam int FL  = 8;

    logic           clk;
    logic           rst;
    logic           clr;
    logic [P_W-1:0] p_in;
    logic           p_valid;
    logic           p_ready;
    logic [P_W-1:0] sum_out;
    logic           sum_valid;
    logic           sum_ready;
    logic           sum_ovf;

    int n_checks;
    int n_fail;

    dsp_accum #(
        .FRAME_LEN (FL),
        .P_W       (P_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .p_in      (p_in),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum_ovf   (sum_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every step leaves the bench 1 time unit after a rising edge.
    task automatic push(input logic [P_W-1:0] v);
        p_valid = 1'b1;
        p_in    = v;
        @(posedge clk);
        #1;
        p_valid = 1'b0;
    endtask

    task automatic push_n(input logic [P_W-1:0] v, input int n);
        for (int i = 0; i < n; i++) push(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input logic [P_W-1:0] s, input logic o);
        check({tag, "_valid"}, 64'(sum_valid), 64'd1);
        check({tag, "_sum"},   64'(sum_out),   64'(s));
        check({tag, "_ovf"},   64'(sum_ovf),   64'(o));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"},  64'(sum_valid), 64'd0);
        check({tag, "_sum"},    64'(sum_out),   64'd0);
        check({tag, "_ovf"},    64'(sum_ovf),   64'd0);
        check({tag, "_pready"}, 64'(p_ready),   64'd1);
    endtask

    function automatic logic [P_W-1:0] dsp_sample();
        logic [17:0]    a;
        logic [17:0]    b;
        logic [17:0]    d;
        logic [P_W-1:0] c;
        a = 18'($urandom);
        b = 18'($urandom);
        d = 18'($urandom);
        c = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 8);
        return (P_W'(b) + P_W'(d)) * P_W'(a) + c;
    endfunction

    logic [P_W:0]   exp_q[$];
    logic [P_W-1:0] m_acc;
    logic [P_W:0]   m_full;
    logic [P_W-1:0] m_sat;
    int             m_cnt;
    logic           m_sticky;
    int             frames;
    int             r_ok;
    int             r_err;
    int             fail_before;
    int             cycles;
    logic           acc_ok;
    logic           hs;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        clr       = 1'b0;
        p_in      = '0;
        p_valid   = 1'b0;
        sum_ready = 1'b1;
        idle(2);
        check_reset("reset");
        rst = 1'b0;
        idle(1);

        // basic frame
        push_n(48'd10, FL);
        check_out("basic", 48'd80, 1'b0);
        idle(1);
        check("basic_onecycle", 64'(sum_valid), 64'd0);

        // saturation then a clean frame
        push(48'hFFFF_FFFF_FFF0);
        push(48'h20);
        push_n(48'd0, 6);
        check_out("sat", 48'hFFFF_FFFF_FFFF, 1'b1);
        push_n(48'd1, FL);
        check_out("after_sat", 48'd8, 1'b0);
        idle(1);

        // all zeros
        push_n(48'd0, FL);
        check_out("zeros", 48'd0, 1'b0);
        idle(1);

        // backpressure: offered samples must not be taken while stalled
        sum_ready = 1'b0;
        push_n(48'd3, FL);
        check_out("bp", 48'd24, 1'b0);
        p_valid = 1'b1;
        p_in    = 48'd100;
        for (int i = 0; i < 5; i++) begin
            check("bp_pready", 64'(p_ready), 64'd0);
            check("bp_hold",   64'(sum_out), 64'd24);
            @(posedge clk);
            #1;
        end
        check_out("bp_end", 48'd24, 1'b0);
        p_valid   = 1'b0;
        sum_ready = 1'b1;
        #1;
        check("bp_release", 64'(p_ready), 64'd1);
        @(posedge clk);
        #1;
        check("bp_hs", 64'(sum_valid), 64'd0);

        // clr mid-frame drops partial sum and the coincident sample
        push_n(48'd5, 3);
        clr = 1'b1;
        push(48'd5);
        clr = 1'b0;
        push_n(48'd1, FL);
        check_out("clr", 48'd8, 1'b0);
        idle(1);

        // async reset during ACCUM
        push_n(48'd9, 3);
        #2 rst = 1'b1;
        #1;
        check_reset("rst_accum");
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        push_n(48'd2, FL);
        check_out("post_rst1", 48'd16, 1'b0);
        idle(1);

        // async reset during OUT_WAIT
        sum_ready = 1'b0;
        push_n(48'd4, FL);
        check_out("ow", 48'd32, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_reset("rst_ow");
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        sum_ready = 1'b1;
        push_n(48'd7, FL);
        check_out("post_rst2", 48'd56, 1'b0);
        idle(1);

        // randomized end-to-end against a reference model
        m_acc = '0; m_cnt = 0; m_sticky = 1'b0;
        frames = 0; r_ok = 0; r_err = 0; cycles = 0;
        while (frames < 100 && cycles < 20000) begin
            p_valid   = ($urandom_range(0, 3) != 0);
            p_in      = dsp_sample();
            sum_ready = ($urandom_range(0, 4) < 3);
            #1;
            acc_ok = p_valid && p_ready;
            hs     = sum_valid && sum_ready;
            if (hs) begin
                fail_before = n_fail;
                if (exp_q.size() > 0)
                    check("rand_frame", 64'({sum_ovf, sum_out}), 64'(exp_q.pop_front()));
                else
                    check("rand_unexpected", 64'd1, 64'd0);
                if (n_fail == fail_before) r_ok++;
                else r_err++;
                frames++;
            end
            if (acc_ok) begin
                m_full   = {1'b0, m_acc} + {1'b0, p_in};
                m_sat    = m_full[P_W] ? {P_W{1'b1}} : m_full[P_W-1:0];
                m_sticky = m_sticky | m_full[P_W];
                if (m_cnt == FL - 1) begin
                    exp_q.push_back({m_sticky, m_sat});
                    m_acc = '0; m_cnt = 0; m_sticky = 1'b0;
                end else begin
                    m_acc = m_sat;
                    m_cnt++;
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        p_valid = 1'b0;
        check("rand_frames_seen", 64'(frames), 64'd100);
        $display("random run: correct=%0d errors=%0d", r_ok, r_err);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
